// File: rtl/redun_mont_pkg.sv
// Shared types for the redundant Montgomery datapath.
//   NUM_WRDS / WRD_BITS : shape of a redundant operand
//   redun0_t            : packed operand, word 0 in the least significant slot
//   iter_state_t        : iteration controller states
package redun_mont_pkg;

  localparam int unsigned NUM_WRDS = 65;
  localparam int unsigned WRD_BITS = 16;

  typedef logic [NUM_WRDS-1:0][WRD_BITS-1:0] redun0_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } iter_state_t;

endpackage

// File: rtl/redun_wdog_cnt.sv
// Watchdog counter for one outstanding squaring.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_load         : restart the count (asserted in the issue cycle)
//   i_en           : count one waiting cycle
//   o_expire_c     : combinational, the current waiting cycle is the last one allowed
module redun_wdog_cnt #(
  parameter int unsigned WDOG_CYC = 256
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire_c
);

  localparam int unsigned CNT_W = (WDOG_CYC > 2) ? $clog2(WDOG_CYC) : 1;
  // The count is 0 in the first waiting cycle after the issue pulse. Expiring
  // when it reads WDOG_CYC-2 lets the owner's registered status change exactly
  // WDOG_CYC cycles after the issue pulse.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WDOG_CYC - 2);

  if (WDOG_CYC < 2) begin : g_bad_wdog
    $fatal(1, "redun_wdog_cnt: WDOG_CYC must be at least 2");
  end

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: restart on load, saturate at the expiry point.
  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = '0;
    end else if (i_en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expire_c = (cnt_q == LAST);

endmodule

// File: rtl/redun_sq_iter_ctrl.sv
// Iteration controller for the redundant Montgomery squarer: takes a start
// value and a count T, runs T back-to-back squarings by feeding each result
// back as the next operand, and returns the final value with sticky status.
//   i_clk, i_rst_n           : clock, synchronous active-low reset
//   i_val/o_rdy/i_sq/i_iter  : start request (value, iteration count)
//   i_abort                  : end the current job early
//   o_mul_sq/o_mul_val       : operand pulse to the squarer
//   i_mul_res/i_mul_val/ovf  : squarer result
//   o_sq/o_val/i_rdy         : final result handshake
//   o_iter_cnt               : squarings completed in the current job
//   o_busy/o_ovf/o_wdog      : job in progress, sticky overflow, sticky timeout
module redun_sq_iter_ctrl
  import redun_mont_pkg::*;
#(
  parameter int unsigned ITER_W   = 40,
  parameter int unsigned WDOG_CYC = 256
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_val,
  output logic              o_rdy,
  input  redun0_t           i_sq,
  input  logic [ITER_W-1:0] i_iter,
  input  logic              i_abort,
  output redun0_t           o_mul_sq,
  output logic              o_mul_val,
  input  redun0_t           i_mul_res,
  input  logic              i_mul_val,
  input  logic              i_mul_ovf,
  output redun0_t           o_sq,
  output logic              o_val,
  input  logic              i_rdy,
  output logic [ITER_W-1:0] o_iter_cnt,
  output logic              o_busy,
  output logic              o_ovf,
  output logic              o_wdog
);

  localparam int unsigned CNT_W = ITER_W + 1;

  if (!((WRD_BITS == 16) || (WRD_BITS == 32))) begin : g_bad_wrd
    $fatal(1, "redun_sq_iter_ctrl: WRD_BITS must be 16 or 32");
  end

  iter_state_t       state_q, state_d;
  redun0_t           sq_q, sq_d;
  logic [ITER_W-1:0] cnt_q, cnt_d;
  logic [ITER_W-1:0] t_q, t_d;
  logic              ovf_q, ovf_d;
  logic              wdog_q, wdog_d;
  logic              rdy_q, busy_q, val_q, mul_val_q;
  logic              wd_load_c, wd_en_c, wd_expire_c;
  logic              last_c;

  // One extra bit so T = 2^ITER_W-1 finishes without the compare wrapping.
  assign last_c = (({1'b0, cnt_q} + CNT_W'(1)) == {1'b0, t_q});

  redun_wdog_cnt #(
    .WDOG_CYC (WDOG_CYC)
  ) u_wdog (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (wd_load_c),
    .i_en       (wd_en_c),
    .o_expire_c (wd_expire_c)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    sq_d      = sq_q;
    cnt_d     = cnt_q;
    t_d       = t_q;
    ovf_d     = ovf_q;
    wdog_d    = wdog_q;
    wd_load_c = 1'b0;
    wd_en_c   = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_val && rdy_q) begin
          sq_d    = i_sq;
          t_d     = i_iter;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          wdog_d  = 1'b0;
          state_d = (i_iter == '0) ? DONE : ISSUE;
        end
      end

      ISSUE: begin
        wd_load_c = 1'b1;
        state_d   = i_abort ? DONE : WAIT;
      end

      WAIT: begin
        wd_en_c = 1'b1;
        // A result in the same cycle as abort or expiry is still taken.
        if (i_mul_val) begin
          sq_d    = i_mul_res;
          cnt_d   = cnt_q + ITER_W'(1);
          ovf_d   = ovf_q | i_mul_ovf;
          state_d = (last_c || i_abort) ? DONE : ISSUE;
        end else if (i_abort) begin
          state_d = DONE;
        end else if (wd_expire_c) begin
          wdog_d  = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        if (val_q && i_rdy) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered strobes decoded from the next state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      sq_q      <= '0;
      cnt_q     <= '0;
      t_q       <= '0;
      ovf_q     <= 1'b0;
      wdog_q    <= 1'b0;
      rdy_q     <= 1'b1;
      busy_q    <= 1'b0;
      val_q     <= 1'b0;
      mul_val_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sq_q      <= sq_d;
      cnt_q     <= cnt_d;
      t_q       <= t_d;
      ovf_q     <= ovf_d;
      wdog_q    <= wdog_d;
      rdy_q     <= (state_d == IDLE);
      busy_q    <= (state_d != IDLE);
      val_q     <= (state_d == DONE);
      mul_val_q <= (state_d == ISSUE);
    end
  end

  // The last completed value doubles as the next squarer operand.
  assign o_mul_sq   = sq_q;
  assign o_mul_val  = mul_val_q;
  assign o_sq       = sq_q;
  assign o_val      = val_q;
  assign o_rdy      = rdy_q;
  assign o_iter_cnt = cnt_q;
  assign o_busy     = busy_q;
  assign o_ovf      = ovf_q;
  assign o_wdog     = wdog_q;

endmodule

// File: tb/tb_redun_sq_iter_ctrl.sv
// Scoreboard bench for redun_sq_iter_ctrl with a behavioural squarer model.
module tb_redun_sq_iter_ctrl;
  import redun_mont_pkg::*;

  localparam int unsigned ITER_W = 4;
  localparam int unsigned WDOG   = 16;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_val = 1'b0;
  logic              o_rdy;
  redun0_t           i_sq = '0;
  logic [ITER_W-1:0] i_iter = '0;
  logic              i_abort = 1'b0;
  redun0_t           o_mul_sq;
  logic              o_mul_val;
  redun0_t           i_mul_res = '0;
  logic              i_mul_val = 1'b0;
  logic              i_mul_ovf = 1'b0;
  redun0_t           o_sq;
  logic              o_val;
  logic              i_rdy = 1'b0;
  logic [ITER_W-1:0] o_iter_cnt;
  logic              o_busy;
  logic              o_ovf;
  logic              o_wdog;

  redun_sq_iter_ctrl #(.ITER_W(ITER_W), .WDOG_CYC(WDOG)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_val(i_val), .o_rdy(o_rdy),
    .i_sq(i_sq), .i_iter(i_iter), .i_abort(i_abort),
    .o_mul_sq(o_mul_sq), .o_mul_val(o_mul_val),
    .i_mul_res(i_mul_res), .i_mul_val(i_mul_val), .i_mul_ovf(i_mul_ovf),
    .o_sq(o_sq), .o_val(o_val), .i_rdy(i_rdy), .o_iter_cnt(o_iter_cnt),
    .o_busy(o_busy), .o_ovf(o_ovf), .o_wdog(o_wdog)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  typedef struct { redun0_t sq; int cnt; bit ovf; bit wdog; } exp_t;
  typedef struct { int due; redun0_t res; bit ovf; } pend_t;

  exp_t    exp_q[$];
  redun0_t op_q[$];
  pend_t   pend_q[$];

  // Squarer model controls, written by the stimulus before each job.
  int          sq_lat = 5;
  int          drop_idx = -1;
  logic [31:0] ovf_mask = '0;
  int          job_base = 0;
  // Squarer model observations.
  int          sq_cyc = 0;
  int          sq_issue_total = 0;
  int          sq_res_total = 0;
  int          last_issue_cyc = 0;
  int          done_cnt = 0;

  task automatic chk(input bit ok, input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Reference squaring: every word squared independently, modulo 2^WRD_BITS.
  function automatic redun0_t sq_fn(input redun0_t x);
    redun0_t r;
    for (int w = 0; w < NUM_WRDS; w++) r[w] = WRD_BITS'(32'(x[w]) * 32'(x[w]));
    return r;
  endfunction

  function automatic redun0_t iter_fn(input redun0_t x, input int n);
    redun0_t r = x;
    for (int k = 0; k < n; k++) r = sq_fn(r);
    return r;
  endfunction

  function automatic redun0_t rand_val();
    redun0_t r;
    for (int w = 0; w < NUM_WRDS; w++) r[w] = WRD_BITS'($urandom);
    return r;
  endfunction

  function automatic bit ovf_of(input logic [31:0] m, input int n);
    return (m & ((32'd1 << n) - 32'd1)) != 32'd0;
  endfunction

  // Squarer model: checks each operand, answers after sq_lat cycles.
  always begin : sq_model
    int      idx;
    pend_t   p;
    redun0_t e;
    @(posedge i_clk);
    #1;
    sq_cyc++;
    if (o_mul_val) begin
      idx = sq_issue_total - job_base;
      last_issue_cyc = sq_cyc;
      if (op_q.size() == 0) begin
        chk(1'b0, "mul_op_unexpected", 128'(o_mul_sq), 128'(0));
      end else begin
        e = op_q.pop_front();
        chk(o_mul_sq == e, "mul_op", 128'(o_mul_sq), 128'(e));
      end
      if (idx != drop_idx) pend_q.push_back('{sq_cyc + sq_lat, sq_fn(o_mul_sq), ovf_mask[idx % 32]});
      sq_issue_total++;
    end
    i_mul_val = 1'b0;
    i_mul_ovf = 1'b0;
    i_mul_res = '0;
    if (pend_q.size() > 0 && pend_q[0].due <= sq_cyc) begin
      p = pend_q.pop_front();
      i_mul_val = 1'b1;
      i_mul_res = p.res;
      i_mul_ovf = p.ovf;
      sq_res_total++;
    end
  end

  // Result monitor: compares every accepted result against the scoreboard.
  always @(negedge i_clk) begin
    exp_t e;
    if (i_rst_n && o_val && i_rdy) begin
      if (exp_q.size() == 0) begin
        chk(1'b0, "res_unexpected", 128'(o_sq), 128'(0));
      end else begin
        e = exp_q.pop_front();
        chk(o_sq == e.sq, "res_sq", 128'(o_sq), 128'(e.sq));
        chk(int'(o_iter_cnt) == e.cnt, "res_cnt", 128'(o_iter_cnt), 128'(e.cnt));
        chk(o_ovf == e.ovf, "res_ovf", 128'(o_ovf), 128'(e.ovf));
        chk(o_wdog == e.wdog, "res_wdog", 128'(o_wdog), 128'(e.wdog));
      end
      done_cnt++;
    end
  end

  task automatic setup(input int lat, input int drop, input logic [31:0] mask);
    sq_lat   = lat;
    drop_idx = drop;
    ovf_mask = mask;
    job_base = sq_issue_total;
  endtask

  task automatic push_ops(input redun0_t s, input int n);
    for (int k = 0; k < n; k++) op_q.push_back(iter_fn(s, k));
  endtask

  // Full-length job: T operands and the T-th iterate as the result.
  task automatic push_normal(input redun0_t s, input int t, input logic [31:0] mask);
    push_ops(s, t);
    exp_q.push_back('{iter_fn(s, t), t, ovf_of(mask, t), 1'b0});
  endtask

  task automatic launch(input redun0_t s, input int t);
    for (int n = 0; n < 500 && !o_rdy; n++) begin
      @(posedge i_clk);
      #2;
    end
    chk(o_rdy, "rdy_timeout", 128'(o_rdy), 128'(1));
    i_sq   = s;
    i_iter = ITER_W'(t);
    i_val  = 1'b1;
    @(posedge i_clk);
    #2;
    i_val = 1'b0;
  endtask

  task automatic wait_done();
    int d0 = done_cnt;
    for (int n = 0; n < 3000; n++) begin
      @(posedge i_clk);
      #2;
      if (done_cnt > d0) break;
      i_rdy = ($urandom_range(3) != 0);
    end
    chk(done_cnt > d0, "job_done_timeout", 128'(done_cnt), 128'(d0 + 1));
  endtask

  task automatic wait_sq_idle();
    for (int n = 0; n < 100 && pend_q.size() != 0; n++) begin
      @(posedge i_clk);
      #2;
    end
    chk(pend_q.size() == 0, "sq_idle_timeout", 128'(pend_q.size()), 128'(0));
  endtask

  task automatic chk_reset_vals(input string nm);
    chk(o_rdy == 1'b1 && o_val == 1'b0 && o_mul_val == 1'b0 && o_busy == 1'b0,
        {nm, "_ctl"}, {o_rdy, o_val, o_mul_val, o_busy}, 128'b1000);
    chk(o_ovf == 1'b0 && o_wdog == 1'b0 && o_iter_cnt == '0,
        {nm, "_stat"}, {o_ovf, o_wdog, o_iter_cnt}, 128'(0));
    chk(o_sq == '0 && o_mul_sq == '0, {nm, "_data"}, 128'(o_sq), 128'(0));
  endtask

  initial begin : global_timeout
    #1000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "global timeout");
  end

  initial begin : stim
    redun0_t s;
    redun0_t ws;
    int      base;
    int      r0;
    int      t;
    logic [31:0] m;

    // Reset values on the first cycle after release.
    repeat (3) @(posedge i_clk);
    #2;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #2;
    chk_reset_vals("reset");

    // Word0 = 3, T = 3: operands 3, 9, 81 and result 6561.
    s = '0;
    s[0] = WRD_BITS'(3);
    setup(5, -1, 32'h0);
    base = sq_issue_total;
    push_normal(s, 3, 32'h0);
    launch(s, 3);
    wait_done();
    chk(sq_issue_total - base == 3, "plan1_issues", 128'(sq_issue_total - base), 128'(3));

    // T = 0 returns the start value one cycle after accept, no squarings.
    s = '0;
    s[0] = WRD_BITS'(16'h1234);
    setup(5, -1, 32'h0);
    base = sq_issue_total;
    exp_q.push_back('{s, 0, 1'b0, 1'b0});
    i_rdy = 1'b0;
    launch(s, 0);
    chk(o_val == 1'b1, "t0_latency", 128'(o_val), 128'(1));
    chk(o_mul_val == 1'b0, "t0_no_mul_val", 128'(o_mul_val), 128'(0));
    wait_done();
    chk(sq_issue_total == base, "t0_no_issue", 128'(sq_issue_total - base), 128'(0));

    // Abort after the 4th result; the 5th (late) result and its ovf are ignored.
    s = rand_val();
    setup(3, -1, 32'h10);
    r0 = sq_res_total;
    push_ops(s, 5);
    exp_q.push_back('{iter_fn(s, 4), 4, 1'b0, 1'b0});
    i_rdy = 1'b0;
    launch(s, 10);
    for (int n = 0; n < 500 && sq_res_total < r0 + 4; n++) begin
      @(posedge i_clk);
      #2;
    end
    chk(sq_res_total >= r0 + 4, "abort_wait_timeout", 128'(sq_res_total - r0), 128'(4));
    @(posedge i_clk);
    #2;
    i_abort = 1'b1;
    @(posedge i_clk);
    #2;
    i_abort = 1'b0;
    wait_sq_idle();
    @(posedge i_clk);
    #2;
    chk(o_val == 1'b1 && o_busy == 1'b1, "abort_done", {o_val, o_busy}, 128'b11);
    chk(o_iter_cnt == ITER_W'(4), "abort_cnt_late", 128'(o_iter_cnt), 128'(4));
    wait_done();

    // Drop the 2nd response: timeout exactly WDOG cycles after the 2nd issue.
    s = rand_val();
    ws = iter_fn(s, 1);
    setup(4, 1, 32'h1);
    push_ops(s, 2);
    exp_q.push_back('{ws, 1, 1'b1, 1'b1});
    i_rdy = 1'b0;
    launch(s, 5);
    for (int n = 0; n < 200 && !o_wdog; n++) begin
      @(posedge i_clk);
      #2;
    end
    chk(o_wdog == 1'b1, "wdog_timeout", 128'(o_wdog), 128'(1));
    chk(sq_cyc - last_issue_cyc == int'(WDOG), "wdog_delay", 128'(sq_cyc - last_issue_cyc), 128'(WDOG));
    // Backpressure: result held for 20 cycles.
    for (int k = 0; k < 20; k++) begin
      chk(o_val == 1'b1 && o_rdy == 1'b0, "hold_ctl", {o_val, o_rdy}, 128'b10);
      chk(o_sq == ws, "hold_sq", 128'(o_sq), 128'(ws));
      @(posedge i_clk);
      #2;
    end
    i_rdy = 1'b1;
    chk(o_rdy == 1'b0, "no_turnaround", 128'(o_rdy), 128'(0));
    @(posedge i_clk);
    #2;
    i_rdy = 1'b0;
    chk(o_rdy == 1'b1 && o_val == 1'b0, "rdy_after_hs", {o_rdy, o_val}, 128'b10);

    // Reset for one cycle during WAIT; the stale result (with ovf) is ignored.
    s = rand_val();
    setup(6, -1, 32'h1);
    push_ops(s, 1);
    base = sq_issue_total;
    launch(s, 4);
    for (int n = 0; n < 50 && sq_issue_total < base + 1; n++) begin
      @(posedge i_clk);
      #2;
    end
    @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    @(posedge i_clk);
    #2;
    i_rst_n = 1'b1;
    chk_reset_vals("mid_reset");
    wait_sq_idle();
    @(posedge i_clk);
    #2;
    chk_reset_vals("stale_ignored");

    // T = 2 with ovf on one response: sticky until the next accept.
    s = rand_val();
    setup(2, -1, 32'h2);
    push_normal(s, 2, 32'h2);
    launch(s, 2);
    wait_done();
    repeat (3) @(posedge i_clk);
    #2;
    chk(o_ovf == 1'b1, "ovf_sticky", 128'(o_ovf), 128'(1));
    s = rand_val();
    setup(2, -1, 32'h0);
    push_normal(s, 1, 32'h0);
    launch(s, 1);
    chk(o_ovf == 1'b0, "ovf_clear_on_accept", 128'(o_ovf), 128'(0));
    wait_done();

    // Maximum count, at the longest latency the watchdog tolerates.
    s = rand_val();
    m = $urandom;
    t = (1 << ITER_W) - 1;
    setup(int'(WDOG) - 1, -1, m);
    push_normal(s, t, m);
    launch(s, t);
    wait_done();

    // Random jobs with random latency, overflow pattern and backpressure.
    for (int j = 0; j < 20; j++) begin
      s = rand_val();
      m = $urandom;
      t = $urandom_range((1 << ITER_W) - 1);
      setup($urandom_range(int'(WDOG) - 1, 1), -1, m);
      push_normal(s, t, m);
      launch(s, t);
      wait_done();
    end

    wait_sq_idle();
    chk(exp_q.size() == 0, "sb_empty", 128'(exp_q.size()), 128'(0));
    chk(op_q.size() == 0, "ops_empty", 128'(op_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
